// File: rtl/psram_responder.sv
// ============================================================================
// psram_responder : dual-chip QPI PSRAM device model backed by a word array
// Rev 1.0
// ============================================================================
`default_nettype none

module psram_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_psram_csn,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_data_oe,
    output logic       o_qpi_mode,
    output logic       o_wr_stb,
    output logic       o_rd_stb,
    output logic       o_err
);
    localparam int WCW   = $clog2(WAIT_CYCLES + 1);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        SPI_CMD   = 3'd0,
        IGNORE    = 3'd1,
        QPI_CMD_H = 3'd2,
        QPI_CMD_L = 3'd3,
        ADDR      = 3'd4,
        WR_DATA   = 3'd5,
        RD_WAIT   = 3'd6,
        RD_DATA   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              qpi_q, qpi_d;
    logic [7:0]        spi_a_q, spi_a_d, spi_b_q, spi_b_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        cmd_hi_q, cmd_hi_d;
    logic              is_wr_q, is_wr_d;
    logic [2:0]        nib_cnt_q, nib_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WCW-1:0]    wait_q, wait_d;
    logic              phase_q, phase_d;
    logic [7:0]        wr_hi_q, wr_hi_d;
    logic [7:0]        data_q, data_d;
    logic              oe_q, oe_d;
    logic              wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d, err_q, err_d;

    logic [15:0]       mem_q [DEPTH];
    logic [15:0]       rd_word_q;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    logic              nib_ok;
    logic [ADDR_W+3:0] addr_shift;

    assign nib_ok     = (i_data[3:0] == i_data[7:4]);
    assign addr_shift = {addr_q, i_data[3:0]};

    always_comb begin
        state_d   = state_q;
        qpi_d     = qpi_q;
        spi_a_d   = spi_a_q;
        spi_b_d   = spi_b_q;
        bit_cnt_d = bit_cnt_q;
        cmd_hi_d  = cmd_hi_q;
        is_wr_d   = is_wr_q;
        nib_cnt_d = nib_cnt_q;
        addr_d    = addr_q;
        wait_d    = wait_q;
        phase_d   = phase_q;
        wr_hi_d   = wr_hi_q;
        data_d    = data_q;
        oe_d      = oe_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr_q;
        // Stored word interleaves the two chips: {B byte, A byte}
        mem_wdata = {wr_hi_q[7:4], i_data[7:4], wr_hi_q[3:0], i_data[3:0]};

        if (i_psram_csn) begin
            state_d   = qpi_q ? QPI_CMD_H : SPI_CMD;
            oe_d      = 1'b0;
            bit_cnt_d = 3'd0;
            nib_cnt_d = 3'd0;
            phase_d   = 1'b0;
            if (state_q == ADDR || (state_q == WR_DATA && phase_q))
                err_d = 1'b1;
        end else begin
            case (state_q)
                SPI_CMD: begin
                    spi_a_d   = {spi_a_q[6:0], i_data[0]};
                    spi_b_d   = {spi_b_q[6:0], i_data[4]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (spi_a_d == 8'h35 && spi_b_d == 8'h35)
                            qpi_d = 1'b1;
                        state_d = IGNORE;
                    end
                end
                QPI_CMD_H: begin
                    if (!nib_ok) begin
                        err_d   = 1'b1;
                        state_d = IGNORE;
                    end else begin
                        cmd_hi_d = i_data[3:0];
                        state_d  = QPI_CMD_L;
                    end
                end
                QPI_CMD_L: begin
                    if (!nib_ok) begin
                        err_d   = 1'b1;
                        state_d = IGNORE;
                    end else begin
                        nib_cnt_d = 3'd0;
                        case ({cmd_hi_q, i_data[3:0]})
                            8'hEB: begin is_wr_d = 1'b0; state_d = ADDR; end
                            8'h38: begin is_wr_d = 1'b1; state_d = ADDR; end
                            8'hF5: begin qpi_d = 1'b0; state_d = IGNORE; end
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (!nib_ok) begin
                        err_d   = 1'b1;
                        state_d = IGNORE;
                    end else begin
                        addr_d    = addr_shift[ADDR_W-1:0];
                        nib_cnt_d = nib_cnt_q + 3'd1;
                        if (nib_cnt_q == 3'd5) begin
                            phase_d = 1'b0;
                            if (is_wr_q) begin
                                state_d = WR_DATA;
                            end else begin
                                mem_re   = 1'b1;
                                mem_addr = addr_d;
                                rd_stb_d = 1'b1;
                                wait_d   = WCW'(1);
                                state_d  = RD_WAIT;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (!phase_q) begin
                        wr_hi_d = i_data;
                        phase_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_stb_d = 1'b1;
                        addr_d   = addr_q + ADDR_W'(1);
                        phase_d  = 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (wait_q == WCW'(WAIT_CYCLES)) begin
                        data_d  = rd_word_q[15:8];
                        oe_d    = 1'b1;
                        phase_d = 1'b0;
                        state_d = RD_DATA;
                    end else begin
                        wait_d = wait_q + WCW'(1);
                    end
                end
                RD_DATA: begin
                    if (!phase_q) begin
                        // Low byte goes out while the next word is fetched
                        data_d   = rd_word_q[7:0];
                        addr_d   = addr_q + ADDR_W'(1);
                        mem_re   = 1'b1;
                        mem_addr = addr_d;
                        phase_d  = 1'b1;
                    end else begin
                        data_d  = rd_word_q[15:8];
                        phase_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= SPI_CMD;
            qpi_q     <= 1'b0;
            spi_a_q   <= 8'h00;
            spi_b_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            cmd_hi_q  <= 4'h0;
            is_wr_q   <= 1'b0;
            nib_cnt_q <= 3'd0;
            addr_q    <= '0;
            wait_q    <= '0;
            phase_q   <= 1'b0;
            wr_hi_q   <= 8'h00;
            data_q    <= 8'h00;
            oe_q      <= 1'b0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            qpi_q     <= qpi_d;
            spi_a_q   <= spi_a_d;
            spi_b_q   <= spi_b_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_hi_q  <= cmd_hi_d;
            is_wr_q   <= is_wr_d;
            nib_cnt_q <= nib_cnt_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            phase_q   <= phase_d;
            wr_hi_q   <= wr_hi_d;
            data_q    <= data_d;
            oe_q      <= oe_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            err_q     <= err_d;
        end
    end

    // Array has no reset so contents survive i_rst
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst)
            mem_q[mem_addr] <= mem_wdata;
        if (mem_re)
            rd_word_q <= mem_q[mem_addr];
    end

    assign o_data     = data_q;
    assign o_data_oe  = oe_q;
    assign o_qpi_mode = qpi_q;
    assign o_wr_stb   = wr_stb_q;
    assign o_rd_stb   = rd_stb_q;
    assign o_err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_psram_responder.sv
// ============================================================================
// tb_psram_responder : directed self-checking bench for psram_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_psram_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       csn;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe, qpi, wr_stb, rd_stb, err;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int err_cnt  = 0;
    int oe_cnt   = 0;
    int w0, r0, e0, o0;

    always #5 clk = ~clk;

    psram_responder #(.ADDR_W(10), .WAIT_CYCLES(5)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_psram_csn (csn),
        .i_data      (din),
        .o_data      (dout),
        .o_data_oe   (oe),
        .o_qpi_mode  (qpi),
        .o_wr_stb    (wr_stb),
        .o_rd_stb    (rd_stb),
        .o_err       (err)
    );

    always @(negedge clk) begin
        if (wr_stb) wr_cnt++;
        if (rd_stb) rd_cnt++;
        if (err)    err_cnt++;
        if (oe)     oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic c, input logic [7:0] d);
        csn = c;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b0, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 8'h00);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send({3'b000, b[i], 3'b000, b[i]});
    endtask

    task automatic qpi_nib(input logic [3:0] n);
        send({n, n});
    endtask

    task automatic qpi_cmd(input logic [7:0] c);
        qpi_nib(c[7:4]);
        qpi_nib(c[3:0]);
    endtask

    task automatic qpi_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) qpi_nib(a[4*i +: 4]);
    endtask

    task automatic read_burst(input string tag, input logic [23:0] a,
                              input logic [31:0] exp, input int n);
        qpi_cmd(8'hEB);
        qpi_addr(a);
        check({tag, "_rd_stb"}, {31'd0, rd_stb}, 32'd1);
        for (int k = 1; k <= 4; k++) send(8'h00);
        check({tag, "_oe_early"}, {31'd0, oe}, 32'd0);
        for (int j = 0; j < n; j++) begin
            send(8'h00);
            check({tag, "_oe"}, {31'd0, oe}, 32'd1);
            check({tag, "_byte"}, {24'd0, dout}, {24'd0, exp[31-8*j -: 8]});
        end
        idle(1);
        check({tag, "_release"}, {31'd0, oe}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        csn = 1'b1;
        din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", {24'd0, dout}, 32'd0);
        check("rst_oe", {31'd0, oe}, 32'd0);
        check("rst_qpi", {31'd0, qpi}, 32'd0);
        check("rst_strobes", {29'd0, wr_stb, rd_stb, err}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Enter-QPI: wrong pattern first, then the real one
        spi_byte(8'h34);
        check("spi_34_qpi", {31'd0, qpi}, 32'd0);
        idle(2);
        spi_byte(8'h35);
        check("spi_35_qpi", {31'd0, qpi}, 32'd1);
        idle(2);

        // Single word write at 0x10
        w0 = wr_cnt;
        qpi_cmd(8'h38);
        qpi_addr(24'h000010);
        send(8'hA5);
        check("wr_hi_no_stb", {31'd0, wr_stb}, 32'd0);
        send(8'h5A);
        check("wr_stb", {31'd0, wr_stb}, 32'd1);
        idle(2);
        check("wr_count1", wr_cnt - w0, 32'd1);
        read_burst("rd10", 24'h000010, 32'hA55A_0000, 2);

        // Burst write crossing the top of the array
        w0 = wr_cnt;
        qpi_cmd(8'h38);
        qpi_addr(24'h0003FF);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        send(8'h78);
        idle(2);
        check("wrap_wr_count", wr_cnt - w0, 32'd2);
        read_burst("wrap_rd", 24'hFFF3FF, 32'h1324_5768, 4);

        // Abort mid-address
        w0 = wr_cnt;
        e0 = err_cnt;
        qpi_cmd(8'h38);
        repeat (3) qpi_nib(4'h0);
        idle(1);
        check("abort_err", {31'd0, err}, 32'd1);
        idle(1);
        check("abort_no_wr", wr_cnt - w0, 32'd0);
        check("abort_err_count", err_cnt - e0, 32'd1);
        read_burst("after_abort", 24'h000010, 32'hA55A_0000, 2);

        // Unknown command
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cnt;
        qpi_cmd(8'h9F);
        repeat (8) send(8'h33);
        idle(2);
        check("bad_cmd_wr", wr_cnt - w0, 32'd0);
        check("bad_cmd_rd", rd_cnt - r0, 32'd0);
        check("bad_cmd_err", err_cnt - e0, 32'd0);
        check("bad_cmd_oe", oe_cnt - o0, 32'd0);

        // A/B mismatch on an address nibble
        r0 = rd_cnt; e0 = err_cnt; o0 = oe_cnt;
        qpi_cmd(8'hEB);
        qpi_nib(4'h0);
        send(8'h12);
        check("mismatch_err", {31'd0, err}, 32'd1);
        repeat (8) send(8'h00);
        idle(2);
        check("mismatch_rd", rd_cnt - r0, 32'd0);
        check("mismatch_oe", oe_cnt - o0, 32'd0);
        check("mismatch_err_count", err_cnt - e0, 32'd1);

        // Exit QPI
        qpi_cmd(8'hF5);
        check("exit_qpi", {31'd0, qpi}, 32'd0);
        idle(2);
        spi_byte(8'h35);
        idle(2);
        check("reenter_qpi", {31'd0, qpi}, 32'd1);

        // Reset while streaming read data
        qpi_cmd(8'hEB);
        qpi_addr(24'h000010);
        repeat (5) send(8'h00);
        check("pre_rst_byte", {24'd0, dout}, 32'h0000_00A5);
        send(8'h00);
        rst = 1'b1;
        send(8'h00);
        check("mid_rst_oe", {31'd0, oe}, 32'd0);
        check("mid_rst_qpi", {31'd0, qpi}, 32'd0);
        check("mid_rst_data", {24'd0, dout}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Array contents survive reset
        spi_byte(8'h35);
        idle(2);
        read_burst("post_rst", 24'h000010, 32'hA55A_0000, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
